// File: rtl/dco_cf_model_pkg.sv
// Shared timing defaults and the period law for the coarse/fine DCO models.
`timescale 1ns/1ps
package dco_cf_model_pkg;

    localparam real DCO_T0_DEF = 8.0;
    localparam real C_STEP_DEF = 0.05;
    localparam real F_STEP_DEF = 0.002;
    localparam real T_MIN_DEF  = 0.5;

    localparam int unsigned SDM_FRW_DEF = 4;

    // Linear period law with a hard floor; reused by the TDC/DCO family.
    function automatic real dco_period(
        input int unsigned coarse,
        input int unsigned fine_eff,
        input real         t0,
        input real         c_step,
        input real         f_step,
        input real         t_min
    );
        real p;
        p = t0 - real'(coarse) * c_step - real'(fine_eff) * f_step;
        if (p < t_min) begin
            p = t_min;
        end
        return p;
    endfunction

endpackage

// File: rtl/dco_cf_model_sdm.sv
// First-order sigma-delta on the fractional fine code; carry is the dither bit for the next period.
`timescale 1ns/1ps
module dco_sdm
    import dco_cf_model_pkg::*;
#(
    parameter int unsigned FRW = SDM_FRW_DEF
) (
    input  logic           clk_i,
    input  logic           reset_,
    input  logic [FRW-1:0] frac_i,
    output logic           carry_c
);

    logic [FRW-1:0] acc_q;
    logic [FRW-1:0] acc_d;

    // Carry reflects the addition that the coming rising edge commits.
    always_comb begin
        carry_c = 1'b0;
        acc_d   = acc_q;
        {carry_c, acc_d} = {1'b0, acc_q} + {1'b0, frac_i};
    end

    always_ff @(posedge clk_i or posedge reset_) begin
        if (reset_) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/dco_cf_model.sv
// Behavioural coarse/fine DCO with sigma-delta fine dither, divided clock, settle flag and edge counter.
`timescale 1ns/1ps
module dco_cf_model
    import dco_cf_model_pkg::*;
#(
    parameter int unsigned CW         = 7,
    parameter int unsigned FW         = 6,
    parameter int unsigned FRW        = 4,
    parameter real         DCO_T0     = DCO_T0_DEF,
    parameter real         C_STEP     = C_STEP_DEF,
    parameter real         F_STEP     = F_STEP_DEF,
    parameter real         T_MIN      = T_MIN_DEF,
    parameter int unsigned DIV_HALF   = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             reset_,
    input  logic             en,
    input  logic [CW-1:0]    coarse,
    input  logic [FW-1:0]    fine,
    input  logic [FRW-1:0]   frac,
    output logic             dco_out,
    output logic             dco_div,
    output logic             stable,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam int unsigned CODE_W   = CW + FW + FRW;
    localparam int unsigned DIV_W    = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int unsigned SET_W    = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam int unsigned FINE_MAX = (1 << FW) - 1;

    logic              carry_c;
    logic              osc_q;
    logic [CODE_W-1:0] code_c;
    logic [CODE_W-1:0] code_prev_q;
    logic [CODE_W-1:0] code_prev_d;
    logic [SET_W-1:0]  settle_q;
    logic [SET_W-1:0]  settle_d;
    logic              stable_q;
    logic              stable_d;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [DIV_W-1:0]  div_cnt_d;
    logic              div_q;
    logic              div_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    dco_sdm #(.FRW(FRW)) u_sdm (
        .clk_i   (dco_out),
        .reset_  (reset_),
        .frac_i  (frac),
        .carry_c (carry_c)
    );

    // Half period from the codes present now, with the dither carry this edge commits.
    function automatic real cur_half();
        int unsigned f_eff;
        f_eff = 32'(fine) + 32'(carry_c);
        if (f_eff > FINE_MAX) begin
            f_eff = FINE_MAX;
        end
        return dco_period(32'(coarse), f_eff, DCO_T0, C_STEP, F_STEP, T_MIN) / 2.0;
    endfunction

    // Oscillator: the run branch is killed the instant reset_ rises.
    always begin : osc_proc
        real half_ns;
        osc_q = 1'b0;
        wait (!reset_ && en);
        fork
            begin : osc_run
                half_ns = cur_half();
                #(half_ns);
                do begin
                    half_ns = cur_half();
                    osc_q   = 1'b1;
                    #(half_ns);
                    osc_q   = 1'b0;
                    #(half_ns);
                end while (en);
            end
            wait (reset_);
        join_any
        disable fork;
    end

    // Reset overrides any edge scheduled in the same timestep.
    assign dco_out = osc_q & ~reset_;

    assign code_c = {coarse, fine, frac};

    always_comb begin
        code_prev_d = code_c;
        settle_d    = settle_q;
        div_cnt_d   = div_cnt_q;
        div_d       = div_q;
        cnt_d       = cnt_q + CNT_W'(1);
        if (code_c != code_prev_q) begin
            settle_d = '0;
        end else if (settle_q < SET_W'(SETTLE_CYC)) begin
            settle_d = settle_q + SET_W'(1);
        end
        stable_d = (settle_d == SET_W'(SETTLE_CYC));
        if (div_cnt_q == DIV_W'(DIV_HALF - 1)) begin
            div_cnt_d = '0;
            div_d     = ~div_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge dco_out or posedge reset_) begin
        if (reset_) begin
            code_prev_q <= '0;
            settle_q    <= '0;
            stable_q    <= 1'b0;
            div_cnt_q   <= '0;
            div_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            code_prev_q <= code_prev_d;
            settle_q    <= settle_d;
            stable_q    <= stable_d;
            div_cnt_q   <= div_cnt_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
        end
    end

    assign dco_div = div_q;
    assign stable  = stable_q;
    assign cyc_cnt = cnt_q;

endmodule
